// File: rtl/vga_sin_gen.sv
// Sine-wave point generator: sweeps 256 columns, one per enabled clock, emitting
// the screen row of one full sine period and a green pixel for each column.
module vga_sin_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [7:0]  CounterX,
    output logic [7:0]  CounterY,
    output logic [11:0] color,
    output logic        finished
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [11:0] COLOR_ON  = 12'h0F0;
    localparam logic [11:0] COLOR_OFF = 12'h000;

    state_t      state_q;
    logic [7:0]  x_q;
    logic [7:0]  y_q;
    logic [11:0] color_q;
    logic        finished_q;

    logic [7:0]  x_d;
    logic [7:0]  y_d;
    logic [1:0]  quad_d;
    logic [6:0]  rom_idx_d;
    logic [6:0]  mag_d;

    // Quarter-wave table: round(127*sin(2*pi*i/256)) for i = 0..64.
    function automatic logic [6:0] quarter_sin(input logic [6:0] idx);
        logic [6:0] v;
        case (idx)
            7'd0:  v = 7'd0;    7'd1:  v = 7'd3;    7'd2:  v = 7'd6;    7'd3:  v = 7'd9;
            7'd4:  v = 7'd12;   7'd5:  v = 7'd16;   7'd6:  v = 7'd19;   7'd7:  v = 7'd22;
            7'd8:  v = 7'd25;   7'd9:  v = 7'd28;   7'd10: v = 7'd31;   7'd11: v = 7'd34;
            7'd12: v = 7'd37;   7'd13: v = 7'd40;   7'd14: v = 7'd43;   7'd15: v = 7'd46;
            7'd16: v = 7'd49;   7'd17: v = 7'd51;   7'd18: v = 7'd54;   7'd19: v = 7'd57;
            7'd20: v = 7'd60;   7'd21: v = 7'd63;   7'd22: v = 7'd65;   7'd23: v = 7'd68;
            7'd24: v = 7'd71;   7'd25: v = 7'd73;   7'd26: v = 7'd76;   7'd27: v = 7'd78;
            7'd28: v = 7'd81;   7'd29: v = 7'd83;   7'd30: v = 7'd85;   7'd31: v = 7'd88;
            7'd32: v = 7'd90;   7'd33: v = 7'd92;   7'd34: v = 7'd94;   7'd35: v = 7'd96;
            7'd36: v = 7'd98;   7'd37: v = 7'd100;  7'd38: v = 7'd102;  7'd39: v = 7'd104;
            7'd40: v = 7'd106;  7'd41: v = 7'd107;  7'd42: v = 7'd109;  7'd43: v = 7'd111;
            7'd44: v = 7'd112;  7'd45: v = 7'd113;  7'd46: v = 7'd115;  7'd47: v = 7'd116;
            7'd48: v = 7'd117;  7'd49: v = 7'd118;  7'd50: v = 7'd120;  7'd51: v = 7'd121;
            7'd52: v = 7'd122;  7'd53: v = 7'd122;  7'd54: v = 7'd123;  7'd55: v = 7'd124;
            7'd56: v = 7'd125;  7'd57: v = 7'd125;  7'd58: v = 7'd126;  7'd59: v = 7'd126;
            7'd60: v = 7'd126;  7'd61: v = 7'd127;  7'd62: v = 7'd127;  7'd63: v = 7'd127;
            7'd64: v = 7'd127;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

    // The row is computed for the column about to be loaded, so X and Y land together.
    always_comb begin
        x_d       = (state_q == IDLE) ? 8'd0 : x_q + 8'd1;
        quad_d    = x_d[7:6];
        rom_idx_d = quad_d[0] ? (7'd64 - {1'b0, x_d[5:0]}) : {1'b0, x_d[5:0]};
        mag_d     = quarter_sin(rom_idx_d);
        // Upper half-period has negative sine, i.e. rows below the centre line.
        y_d       = quad_d[1] ? (8'd128 + {1'b0, mag_d}) : (8'd128 - {1'b0, mag_d});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= 8'd0;
            y_q        <= 8'd0;
            color_q    <= COLOR_OFF;
            finished_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= DRAW;
                        x_q     <= x_d;
                        y_q     <= y_d;
                        color_q <= COLOR_ON;
                    end
                end
                DRAW: begin
                    if (!enable) begin
                        color_q <= COLOR_OFF;
                    end else if (x_q == 8'd255) begin
                        state_q    <= DONE;
                        finished_q <= 1'b1;
                        color_q    <= COLOR_OFF;
                    end else begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        color_q <= COLOR_ON;
                    end
                end
                DONE: begin
                    finished_q <= 1'b1;
                    color_q    <= COLOR_OFF;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign CounterX = x_q;
    assign CounterY = y_q;
    assign color    = color_q;
    assign finished = finished_q;

endmodule

// File: tb/tb_vga_sin_gen.sv
// Self-checking bench for vga_sin_gen: a behavioural model with a floating-point
// sine feeds a scoreboard queue; reference rows are checked from a vector table.
module tb_vga_sin_gen;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  CounterX;
    logic [7:0]  CounterY;
    logic [11:0] color;
    logic        finished;

    vga_sin_gen dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .CounterX (CounterX),
        .CounterY (CounterY),
        .color    (color),
        .finished (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] c;
        logic        f;
    } exp_t;

    typedef struct {
        int x;
        int y;
    } ref_vec_t;

    exp_t sbq[$];
    int   total;
    int   bad;
    int   txn;

    // Behavioural model state
    int   m_st;   // 0 idle, 1 draw, 2 done
    int   m_x;
    int   m_y;
    int   m_c;
    int   m_f;

    int   obs_y [256];

    function automatic int yref(input int x);
        real s;
        int  r;
        s = 127.0 * $sin(2.0 * 3.14159265358979 * real'(x) / 256.0);
        if (s >= 0.0) r = $rtoi(s + 0.5);
        else          r = -$rtoi(-s + 0.5);
        return 128 - r;
    endfunction

    task automatic model_reset();
        m_st = 0; m_x = 0; m_y = 0; m_c = 0; m_f = 0;
    endtask

    task automatic model_step(input logic en);
        case (m_st)
            0: if (en) begin m_st = 1; m_x = 0; m_y = yref(0); m_c = 12'h0F0; end
            1: begin
                if (!en) m_c = 0;
                else if (m_x == 255) begin m_st = 2; m_f = 1; m_c = 0; end
                else begin m_x = m_x + 1; m_y = yref(m_x); m_c = 12'h0F0; end
            end
            default: ;
        endcase
    endtask

    task automatic check_now(input string name, input logic [7:0] ex, input logic [7:0] ey,
                             input logic [11:0] ec, input logic ef);
        total++;
        if (CounterX !== ex || CounterY !== ey || color !== ec || finished !== ef) begin
            bad++;
            $display("FAIL %s: got X=%0d Y=%0d color=%h fin=%b, want X=%0d Y=%0d color=%h fin=%b",
                     name, CounterX, CounterY, color, finished, ex, ey, ec, ef);
        end
    endtask

    // One enabled/disabled clock: predict, push, clock, pop and compare.
    task automatic cyc(input logic en);
        exp_t e;
        enable = en;
        model_step(en);
        e.x = m_x[7:0]; e.y = m_y[7:0]; e.c = m_c[11:0]; e.f = m_f[0];
        sbq.push_back(e);
        @(posedge clk);
        #1;
        txn++;
        if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: queue empty, want 1 entry");
        end else begin
            e = sbq.pop_front();
            check_now("cycle", e.x, e.y, e.c, e.f);
        end
        if (color == 12'h0F0) obs_y[CounterX] = int'(CounterY);
        $display("tx %0d en=%b X=%0d Y=%0d color=%h fin=%b", txn, en, CounterX, CounterY, color, finished);
    endtask

    ref_vec_t refs [8];
    int       cnt;

    initial begin
        total = 0; bad = 0; txn = 0;
        for (int i = 0; i < 256; i++) obs_y[i] = -1;
        refs[0] = '{0, 128};  refs[1] = '{16, 79};  refs[2] = '{32, 38};  refs[3] = '{64, 1};
        refs[4] = '{96, 38};  refs[5] = '{128, 128}; refs[6] = '{192, 255}; refs[7] = '{255, 131};

        // Reset pulse with enable low
        reset = 1'b1; enable = 1'b0;
        #7;
        check_now("reset_state", 8'd0, 8'd0, 12'h000, 1'b0);
        #3 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0);

        // Uninterrupted sweep, plus one more edge for finished
        for (int i = 0; i < 257; i++) cyc(1'b1);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (obs_y[refs[i].x] != refs[i].y) begin
                bad++;
                $display("FAIL ref_row X=%0d: got Y=%0d want %0d", refs[i].x, obs_y[refs[i].x], refs[i].y);
            end
        end

        // Enable toggling in DONE has no effect
        for (int i = 0; i < 20; i++) cyc(1'($urandom_range(0, 1)));

        // Pause at X=100 for 5 cycles
        #2 reset = 1'b1;
        #1 check_now("reset_after_done", 8'd0, 8'd0, 12'h000, 1'b0);
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 101; i++) cyc(1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0);
        cnt = 106;
        while (finished !== 1'b1 && cnt < 400) begin
            cyc(1'b1);
            cnt++;
        end
        total++;
        if (cnt != 262) begin
            bad++;
            $display("FAIL pause_latency: got finished after %0d edges, want 262", cnt);
        end

        // Reset mid-sweep with enable held high
        #2 reset = 1'b1;
        #1 check_now("reset_idle_async", 8'd0, 8'd0, 12'h000, 1'b0);
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 51; i++) cyc(1'b1);
        total++;
        if (CounterX !== 8'd50) begin
            bad++;
            $display("FAIL mid_sweep_pos: got X=%0d want 50", CounterX);
        end
        #2 reset = 1'b1;
        #1 check_now("reset_mid_async", 8'd0, 8'd0, 12'h000, 1'b0);
        @(posedge clk); #1;
        check_now("reset_held", 8'd0, 8'd0, 12'h000, 1'b0);
        reset = 1'b0;
        model_reset();
        cyc(1'b1);
        check_now("restart_point0", 8'd0, 8'd128, 12'h0F0, 1'b0);
        for (int i = 0; i < 256; i++) cyc(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
